// File: rtl/riscv_cache_mem_arbiter_pkg.sv
// Shared message layout, memory request types and port IDs for the
// icache/dcache to main-memory arbiter.
package riscv_cache_mem_arbiter_pkg;

    localparam int REQ_MSG_SZ  = 67;
    localparam int RESP_MSG_SZ = 35;

    // Request fields: type[66], addr[65:34], len[33:32], data[31:0]
    localparam int REQ_TYPE_BIT = 66;
    localparam int REQ_ADDR_LSB = 34;
    localparam int REQ_LEN_LSB  = 32;
    localparam int REQ_DATA_LSB = 0;

    // Response fields: type[34], len[33:32], data[31:0]
    localparam int RESP_TYPE_BIT = 34;
    localparam int RESP_LEN_LSB  = 32;
    localparam int RESP_DATA_LSB = 0;

    localparam logic MEM_TYPE_READ  = 1'b0;
    localparam logic MEM_TYPE_WRITE = 1'b1;

    typedef enum logic {
        PORT_ICACHE = 1'b0,
        PORT_DCACHE = 1'b1
    } port_id_e;

endpackage

// File: rtl/riscv_tag_fifo.sv
// 1-bit-wide synchronous FIFO holding the port ID of each outstanding memory
// request; full/empty come from the registered count, so there is no bypass.
module riscv_tag_fifo #(
    parameter int DEPTH  = 4,
    parameter int PTR_SZ = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_val,
    input  logic              enq_data,
    input  logic              deq_val,
    output logic              deq_data,
    output logic              full,
    output logic              empty,
    output logic [PTR_SZ:0]   count
);

    logic [DEPTH-1:0]  mem;
    logic [PTR_SZ-1:0] wr_ptr;
    logic [PTR_SZ-1:0] rd_ptr;
    logic              do_enq;
    logic              do_deq;

    assign full     = (count == (PTR_SZ+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_enq   = enq_val && !full;
    assign do_deq   = deq_val && !empty;
    assign deq_data = mem[rd_ptr];

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap for free because DEPTH is a power of two.
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_SZ+1)'(do_enq) - (PTR_SZ+1)'(do_deq);
        end
    end

    // NOTE: storage is not reset; the count gates every read of a stale entry.
    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/riscv_cache_mem_arbiter.sv
// Round-robin merge of icache/dcache request streams onto one memory port,
// with in-order responses steered back by a grant-tag FIFO.
module riscv_cache_mem_arbiter
    import riscv_cache_mem_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH  = 4,
    parameter int TAG_PTR_SZ = 2
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [REQ_MSG_SZ-1:0]   req0_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [RESP_MSG_SZ-1:0]  resp0_msg,

    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [REQ_MSG_SZ-1:0]   req1_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [RESP_MSG_SZ-1:0]  resp1_msg,

    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [REQ_MSG_SZ-1:0]   memreq_msg,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [RESP_MSG_SZ-1:0]  memresp_msg,

    output logic [TAG_PTR_SZ:0]     outstanding
);

    port_id_e prio;
    port_id_e grant;
    logic     fifo_full;
    logic     fifo_empty;
    logic     head_tag;
    logic     can_issue;
    logic     req_fire;
    logic     resp_fire;
    logic     head_is_dcache;

    // NOTE: default first so no path through this block can infer a latch.
    always_comb begin
        grant = PORT_ICACHE;
        if (req0_val && req1_val) grant = prio;
        else if (req1_val)        grant = PORT_DCACHE;
    end

    // Request side depends only on req_* and registered FIFO state.
    assign can_issue  = memreq_rdy && !fifo_full;
    assign memreq_val = (req0_val || req1_val) && !fifo_full;
    assign memreq_msg = (grant == PORT_DCACHE) ? req1_msg : req0_msg;
    assign req0_rdy   = can_issue && req0_val && (grant == PORT_ICACHE);
    assign req1_rdy   = can_issue && req1_val && (grant == PORT_DCACHE);
    assign req_fire   = memreq_val && memreq_rdy;

    always_ff @(posedge clk) begin
        if (reset)         prio <= PORT_ICACHE;
        else if (req_fire) prio <= (grant == PORT_ICACHE) ? PORT_DCACHE : PORT_ICACHE;
    end

    // Response side: the head tag names the cache that issued the oldest request.
    assign head_is_dcache = (head_tag == PORT_DCACHE);
    assign resp0_val   = memresp_val && !fifo_empty && !head_is_dcache;
    assign resp1_val   = memresp_val && !fifo_empty &&  head_is_dcache;
    assign resp0_msg   = memresp_msg;
    assign resp1_msg   = memresp_msg;
    assign memresp_rdy = !fifo_empty && (head_is_dcache ? resp1_rdy : resp0_rdy);
    assign resp_fire   = memresp_val && memresp_rdy;

    riscv_tag_fifo #(
        .DEPTH  (TAG_DEPTH),
        .PTR_SZ (TAG_PTR_SZ)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (req_fire),
        .enq_data (grant),
        .deq_val  (resp_fire),
        .deq_data (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (outstanding)
    );

endmodule

// File: doc/riscv_cache_mem_arbiter.md
Name: riscv_cache_mem_arbiter

Overview:
Sits directly downstream of the instruction and data caches. Merges their two cachereq/cacheresp streams onto the single main-memory port. Round-robin arbitration between the two request ports. Routes in-order memory responses back to the originating cache through a grant-tag FIFO.

Parameters:
TAG_DEPTH, 4, maximum outstanding memory requests (FIFO entries, power of two, >=2)
TAG_PTR_SZ, 2, log2(TAG_DEPTH)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
req0_val  in  1  port 0 (icache) request valid
req0_rdy  out  1  port 0 request accepted this cycle
req0_msg  in  67  VC_MEM_REQ_MSG_SZ(32,32): type[66], addr[65:34], len[33:32], data[31:0]
resp0_val  out  1  port 0 response valid
resp0_rdy  in  1  port 0 ready for response
resp0_msg  out  35  VC_MEM_RESP_MSG_SZ(32): type[34], len[33:32], data[31:0]
req1_val / req1_rdy / req1_msg  in/out/in  1/1/67  port 1 (dcache), same format
resp1_val / resp1_rdy / resp1_msg  out/in/out  1/1/35  port 1, same format
memreq_val  out  1  memory request valid
memreq_rdy  in  1  memory accepts request
memreq_msg  out  67  forwarded request, unmodified
memresp_val  in  1  memory response valid
memresp_rdy  out  1  arbiter accepts response
memresp_msg  in  35  memory response, in request order
outstanding  out  TAG_PTR_SZ+1  current tag-FIFO occupancy (debug)

Behaviour:
- Reset: tag FIFO empty, occupancy 0, priority pointer = port 0. All rdy/val outputs 0 while FIFO empty and no req_val asserted.
- Request path is combinational, zero added latency. can_issue = memreq_rdy && !fifo_full.
- Grant when both ports are valid: the port the priority pointer selects. When one port is valid: that port.
- memreq_val = (req0_val || req1_val) && !fifo_full. memreq_msg = granted port's msg.
- reqN_rdy = 1 only for the granted port and only when can_issue. The non-granted port's rdy = 0.
- On a fire (memreq_val && memreq_rdy):
  - push the granted port ID (1 bit) into the tag FIFO.
  - set the priority pointer to the other port. The pointer is unchanged on cycles with no fire.
- Response path is combinational. Head tag h selects the destination.
  - resp_h_val = memresp_val && !fifo_empty. The other port's resp_val = 0.
  - memresp_rdy = !fifo_empty && resp_h_rdy. Both resp msgs = memresp_msg, and only the val qualifies.
  - On a response fire, pop the FIFO.
- memresp_val with an empty FIFO is a protocol error: memresp_rdy = 0, never dropped. The bench flags it.
- Same-cycle push and pop:
  - Both allowed. Occupancy is unchanged and the pointers both advance, wrapping modulo TAG_DEPTH.
  - Full is evaluated on registered occupancy, so push is blocked when full even if a pop happens the same cycle. No bypass.
  - Empty is evaluated on registered occupancy, so a request issued this cycle cannot have its response accepted the same cycle.
- Occupancy wraps never: it saturates logically at TAG_DEPTH through the full gating.
- Reset mid-operation: FIFO cleared and pointer reset to 0. In-flight memory responses after reset are error cases as above. The memory is reset on the same signal.
- No combinational path from memresp_* to memreq_* or req*_rdy.

Decomposition:
- Shared package/header: request/response message widths and field offsets (type, addr, len, data), read/write type encodings, port ID constants (ICACHE=0, DCACHE=1).
- One sub-module: riscv_tag_fifo, a 1-bit-wide, TAG_DEPTH-deep synchronous FIFO with enq/deq, full/empty and count.
- Arbitration and routing logic live in the top level.

Test Plan:
- Single read, port 0 (addr 0x00001000), memory responds data 0xDEADBEEF 3 cycles later -> resp0_val for exactly one cycle, resp1_val stays 0, outstanding 0->1->0.
- Both ports valid every cycle from reset, memreq_rdy=1 -> grants alternate 0,1,0,1; each req_rdy pulses on alternate cycles.
- Issue 4 requests with no responses -> outstanding=4, memreq_val=0, both req_rdy=0. One response pops, next cycle memreq_val=1.
- Interleaved order: port 1 write (addr 0x2000, data 0x12345678), then port 0 read -> first response goes to port 1, second to port 0.
- Backpressure: resp0_rdy=0 for 5 cycles with the head tag 0 -> memresp_rdy=0, FIFO unchanged. The response delivers on the cycle resp0_rdy rises.
- Same-cycle push and pop at occupancy 2 -> occupancy stays 2 and order is preserved. Reset asserted with 3 outstanding -> outstanding=0 and the pointer returns to port 0 the next cycle.
